cpu7_csr_intc: RTL

- Parametrised successor CSR file for the cpu7 core. Holds CRMD, PRMD, ERA and EENTRY with exception and ERTN update semantics.
- Adds ECFG and ESTAT with cause code, NUM_HWI hardware-interrupt lines and two software interrupts.
- Adds a countdown timer (TID/TCFG/TVAL/TICLR), optionally compiled.
- Sits beside the _e-stage exception control and produces the interrupt request consumed by ecl.

---
 rtl/cpu7_csr_intc_if.sv | 15 +
 rtl/cpu7_csr_intc.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/cpu7_csr_intc_if.sv
// cpu7_csr_intc_if: CSR read/write port bundle between the _e stage and the CSR file.
`ifndef LSOC1K_CSR_BIT
`define LSOC1K_CSR_BIT 14
`endif

interface cpu7_csr_intc_if #(parameter int GRLEN = 32);
  logic [`LSOC1K_CSR_BIT-1:0] csr_raddr;
  logic [GRLEN-1:0]           csr_rdata;
  logic [`LSOC1K_CSR_BIT-1:0] csr_waddr;
  logic [GRLEN-1:0]           csr_wdata;
  logic                       csr_wen;

  modport master (output csr_raddr, csr_waddr, csr_wdata, csr_wen, input csr_rdata);
  modport slave  (input csr_raddr, csr_waddr, csr_wdata, csr_wen, output csr_rdata);
endinterface

// File: rtl/cpu7_csr_intc.sv
// cpu7_csr_intc: CRMD/PRMD/ECFG/ESTAT/ERA/EENTRY CSR file with interrupt request
// generation. Countdown timer (TID/TCFG/TVAL/TICLR) is built only when the
// macro CPU7_CSR_TIMER_EN is defined; otherwise those addresses read 0.
`ifndef LSOC1K_CSR_BIT
`define LSOC1K_CSR_BIT 14
`endif

module cpu7_csr_intc #(
  parameter int GRLEN   = 32,
  parameter int NUM_HWI = 8,
  parameter int TIMER_W = 32
) (
  input  logic               clk,
  input  logic               resetn,
  cpu7_csr_intc_if.slave     csr,
  input  logic               ecl_csr_exc_e,
  input  logic [5:0]         ecl_csr_ecode_e,
  input  logic               ecl_csr_ertn_e,
  input  logic [GRLEN-1:0]   ifu_exu_pc_e,
  input  logic [NUM_HWI-1:0] hwi_in,
  output logic [GRLEN-1:0]   csr_eentry,
  output logic [GRLEN-1:0]   csr_era,
  output logic               csr_int_req
);
  localparam int AW = `LSOC1K_CSR_BIT;
  localparam logic [AW-1:0] A_CRMD   = 'h0;
  localparam logic [AW-1:0] A_PRMD   = 'h1;
  localparam logic [AW-1:0] A_ECFG   = 'h4;
  localparam logic [AW-1:0] A_ESTAT  = 'h5;
  localparam logic [AW-1:0] A_ERA    = 'h6;
  localparam logic [AW-1:0] A_EENTRY = 'hc;
`ifdef CPU7_CSR_TIMER_EN
  localparam logic [AW-1:0] A_TID    = 'h40;
  localparam logic [AW-1:0] A_TCFG   = 'h41;
  localparam logic [AW-1:0] A_TVAL   = 'h42;
  localparam logic [AW-1:0] A_TICLR  = 'h44;
`endif

  logic [GRLEN-1:0] wd;
  logic             exc, ertn;
  assign wd   = csr.csr_wdata;
  assign exc  = ecl_csr_exc_e;
  assign ertn = ecl_csr_ertn_e;

  logic w_crmd, w_prmd, w_ecfg, w_estat, w_era, w_eentry;
  assign w_crmd   = csr.csr_wen && csr.csr_waddr == A_CRMD;
  assign w_prmd   = csr.csr_wen && csr.csr_waddr == A_PRMD;
  assign w_ecfg   = csr.csr_wen && csr.csr_waddr == A_ECFG;
  assign w_estat  = csr.csr_wen && csr.csr_waddr == A_ESTAT;
  assign w_era    = csr.csr_wen && csr.csr_waddr == A_ERA;
  assign w_eentry = csr.csr_wen && csr.csr_waddr == A_EENTRY;

  logic [1:0]              plv, pplv, is_sw;
  logic                    ie, pie, ti, int_req_q;
  logic [12:0]             lie, is_v;
  logic [5:0]              ecode;
  logic [GRLEN-1:0]        era, eentry;
  logic [1:0][NUM_HWI-1:0] hwi_sync;

  // CRMD/PRMD: exc saves and clears privilege, ertn restores it; CSR writes yield to both
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      plv <= '0; ie <= 1'b0; pplv <= '0; pie <= 1'b0;
    end else if (exc) begin
      pplv <= plv; pie <= ie; plv <= '0; ie <= 1'b0;
    end else begin
      if (ertn) begin
        plv <= pplv; ie <= pie;
      end else if (w_crmd) begin
        plv <= wd[1:0]; ie <= wd[2];
      end
      if (w_prmd) begin
        pplv <= wd[1:0]; pie <= wd[2];
      end
    end

  // ERA captures the faulting PC; EENTRY and ECFG are plain RW
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      era <= '0; eentry <= '0; lie <= '0;
    end else begin
      if (exc)        era <= ifu_exu_pc_e;
      else if (w_era) era <= wd;
      if (w_eentry)   eentry <= wd;
      if (w_ecfg)     lie <= wd[12:0];
    end

  // ESTAT: cause code from ecl, software interrupt bits from CSR writes
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      ecode <= '0; is_sw <= '0;
    end else begin
      if (exc)     ecode <= ecl_csr_ecode_e;
      if (w_estat) is_sw <= wd[1:0];
    end

  // two-flop synchroniser; stage 1 feeds IS directly
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) hwi_sync <= '0;
    else         hwi_sync <= {hwi_sync[0], hwi_in};

`ifdef CPU7_CSR_TIMER_EN
  logic [GRLEN-1:0]   tid;
  logic               t_en, t_per;
  logic [TIMER_W-3:0] t_init;
  logic [TIMER_W-1:0] tval;
  logic               w_tid, w_tcfg, w_ticlr, t_fire;
  assign w_tid   = csr.csr_wen && csr.csr_waddr == A_TID;
  assign w_tcfg  = csr.csr_wen && csr.csr_waddr == A_TCFG;
  assign w_ticlr = csr.csr_wen && csr.csr_waddr == A_TICLR && wd[0];
  assign t_fire  = t_en && tval == TIMER_W'(1);

  // TID is software scratch/ID
  always_ff @(posedge clk or negedge resetn)
    if (!resetn)    tid <= '0;
    else if (w_tid) tid <= wd;

  // countdown: TCFG write reloads and beats expiry; expiry reloads or stops one-shot
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      t_en <= 1'b0; t_per <= 1'b0; t_init <= '0; tval <= '0;
    end else if (w_tcfg) begin
      t_en <= wd[0]; t_per <= wd[1]; t_init <= wd[TIMER_W-1:2];
      tval <= {wd[TIMER_W-1:2], 2'b00};
    end else if (t_fire) begin
      if (t_per) tval <= {t_init, 2'b00};
      else begin
        tval <= '0; t_en <= 1'b0;
      end
    end else if (t_en && tval != '0) begin
      tval <= tval - TIMER_W'(1);
    end

  // timer interrupt: expiry set wins over TICLR
  always_ff @(posedge clk or negedge resetn)
    if (!resetn)      ti <= 1'b0;
    else if (t_fire)  ti <= 1'b1;
    else if (w_ticlr) ti <= 1'b0;
`else
  assign ti = 1'b0;
`endif

  // IS assembly: sw[1:0], hw[NUM_HWI+1:2], timer[11]
  always_comb begin
    is_v = '0;
    is_v[1:0] = is_sw;
    is_v[NUM_HWI+1:2] = hwi_sync[1];
    is_v[11] = ti;
  end

  // request is registered and suppressed right after an exception is taken
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) int_req_q <= 1'b0;
    else         int_req_q <= exc ? 1'b0 : (ie && |(is_v & lie));

  // combinational read mux, unmapped addresses read 0
  always_comb begin
    csr.csr_rdata = '0;
    case (csr.csr_raddr)
      A_CRMD:   csr.csr_rdata = GRLEN'({ie, plv});
      A_PRMD:   csr.csr_rdata = GRLEN'({pie, pplv});
      A_ECFG:   csr.csr_rdata = GRLEN'(lie);
      A_ESTAT:  csr.csr_rdata = GRLEN'({ecode, 3'b000, is_v});
      A_ERA:    csr.csr_rdata = era;
      A_EENTRY: csr.csr_rdata = eentry;
`ifdef CPU7_CSR_TIMER_EN
      A_TID:    csr.csr_rdata = tid;
      A_TCFG:   csr.csr_rdata = GRLEN'({t_init, t_per, t_en});
      A_TVAL:   csr.csr_rdata = GRLEN'(tval);
`endif
      default:  csr.csr_rdata = '0;
    endcase
  end

  assign csr_eentry  = eentry;
  assign csr_era     = era;
  assign csr_int_req = int_req_q;
endmodule
